load_store_unit: RTL and testbench

- Processor-side initiator for the 64-bit data memory port.
- Accepts one load/store per transaction from the execute stage and validates alignment and range.
- Drives a doubleword-wide memory request with byte enables and holds it until acknowledged.
- Extracts and extends load data, returns one response pulse, and stalls the pipeline while busy.

---
 rtl/load_store_unit.sv | 216 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: takes one load or store from the execute stage, checks
// alignment and address range, issues a doubleword-wide memory request with
// byte enables, and returns a single-cycle response with extended load data.
module load_store_unit #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1; the timeout fires on the
    // last ack-less REQ cycle so mem_req is high for exactly TIMEOUT cycles.
    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

    // Byte-enable pattern for a store of the given size at the given lane offset.
    function automatic logic [7:0] lane_be(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // Pull the addressed bytes out of a doubleword and sign/zero-extend them.
    function automatic logic [63:0] extend_load(input logic [63:0] dword, input logic [2:0] offset,
                                                input logic [1:0] size, input logic is_unsigned);
        logic [63:0] shifted;
        logic [63:0] result;
        shifted = dword >> {offset, 3'b000};
        case (size)
            2'b00:   result = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'b01:   result = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'b10:   result = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    state_t             state_r;
    logic               we_r;
    logic [1:0]         size_r;
    logic               unsigned_r;
    logic [2:0]         offset_r;
    logic [CNT_W-1:0]   wait_cnt_r;

    logic               req_ready_r;
    logic               resp_valid_r;
    logic [63:0]        resp_rdata_r;
    logic               resp_misaligned_r;
    logic               resp_err_r;
    logic               stall_r;
    logic               mem_req_r;
    logic               mem_we_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [63:0]        mem_wdata_r;
    logic [7:0]         mem_be_r;

    logic               misaligned_s;
    logic               out_of_range_s;
    logic [7:0]         st_be_s;
    logic [63:0]        st_wdata_s;
    logic [63:0]        load_data_s;

    assign req_ready       = req_ready_r;
    assign resp_valid      = resp_valid_r;
    assign resp_rdata      = resp_rdata_r;
    assign resp_misaligned = resp_misaligned_r;
    assign resp_err        = resp_err_r;
    assign stall           = stall_r;
    assign mem_req         = mem_req_r;
    assign mem_we          = mem_we_r;
    assign mem_addr        = mem_addr_r;
    assign mem_wdata       = mem_wdata_r;
    assign mem_be          = mem_be_r;

    assign load_data_s = extend_load(mem_rdata, offset_r, size_r, unsigned_r);

    // Request decode: alignment, range and store lane placement.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_size)
            2'b01:   misaligned_s = req_addr[0];
            2'b10:   misaligned_s = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned_s = (req_addr[2:0] != 3'b000);
            default: misaligned_s = 1'b0;
        endcase
        out_of_range_s = |req_addr[63:ADDR_W+3];
        if (req_we) begin
            st_be_s    = lane_be(req_size, req_addr[2:0]);
            st_wdata_s = req_wdata << {req_addr[2:0], 3'b000};
        end else begin
            st_be_s    = 8'hFF;
            st_wdata_s = 64'd0;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            we_r              <= 1'b0;
            size_r            <= 2'b00;
            unsigned_r        <= 1'b0;
            offset_r          <= 3'd0;
            wait_cnt_r        <= {CNT_W{1'b0}};
            req_ready_r       <= 1'b1;
            resp_valid_r      <= 1'b0;
            resp_rdata_r      <= 64'd0;
            resp_misaligned_r <= 1'b0;
            resp_err_r        <= 1'b0;
            stall_r           <= 1'b0;
            mem_req_r         <= 1'b0;
            mem_we_r          <= 1'b0;
            mem_addr_r        <= {ADDR_W{1'b0}};
            mem_wdata_r       <= 64'd0;
            mem_be_r          <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r        <= req_we;
                        size_r      <= req_size;
                        unsigned_r  <= req_unsigned;
                        offset_r    <= req_addr[2:0];
                        wait_cnt_r  <= {CNT_W{1'b0}};
                        req_ready_r <= 1'b0;
                        stall_r     <= 1'b1;
                        if (misaligned_s || out_of_range_s) begin
                            // Rejected requests never touch memory.
                            state_r           <= RESP;
                            resp_valid_r      <= 1'b1;
                            resp_rdata_r      <= 64'd0;
                            resp_misaligned_r <= misaligned_s;
                            resp_err_r        <= out_of_range_s;
                        end else begin
                            state_r     <= REQ;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_we;
                            mem_addr_r  <= req_addr[ADDR_W+2:3];
                            mem_wdata_r <= st_wdata_s;
                            mem_be_r    <= st_be_s;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack || (TIMEOUT_EN && (wait_cnt_r == CNT_LAST))) begin
                        // An ack on the timeout cycle takes priority.
                        state_r           <= RESP;
                        resp_valid_r      <= 1'b1;
                        resp_rdata_r      <= (mem_ack && !we_r) ? load_data_s : 64'd0;
                        resp_misaligned_r <= 1'b0;
                        resp_err_r        <= !mem_ack;
                        mem_req_r         <= 1'b0;
                        mem_we_r          <= 1'b0;
                        mem_addr_r        <= {ADDR_W{1'b0}};
                        mem_wdata_r       <= 64'd0;
                        mem_be_r          <= 8'h00;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r           <= IDLE;
                    resp_valid_r      <= 1'b0;
                    resp_rdata_r      <= 64'd0;
                    resp_misaligned_r <= 1'b0;
                    resp_err_r        <= 1'b0;
                    stall_r           <= 1'b0;
                    req_ready_r       <= 1'b1;
                end
                default: begin
                    state_r           <= IDLE;
                    resp_valid_r      <= 1'b0;
                    resp_rdata_r      <= 64'd0;
                    resp_misaligned_r <= 1'b0;
                    resp_err_r        <= 1'b0;
                    stall_r           <= 1'b0;
                    req_ready_r       <= 1'b1;
                    mem_req_r         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: expected memory requests and responses are queued
// when a request is driven and compared by a negedge monitor, which also acts
// as the memory responder with a programmable ack delay.
module tb_load_store_unit;

    localparam int ADDR_W   = 8;
    localparam int TIMEOUT  = 16;
    localparam int NEVER    = 1000;
    localparam int K_NONE   = 0;
    localparam int K_ACCEPT = 1;
    localparam int K_ACK    = 2;

    logic              clk          = 1'b0;
    logic              rst_n        = 1'b1;
    logic              req_valid    = 1'b0;
    logic              req_we       = 1'b0;
    logic [1:0]        req_size     = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [63:0]       req_addr     = 64'd0;
    logic [63:0]       req_wdata    = 64'd0;
    logic              mem_ack      = 1'b0;
    logic [63:0]       mem_rdata    = 64'd0;
    logic              req_ready;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_misaligned;
    logic              resp_err;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_be;

    typedef struct {
        logic        we;
        logic [63:0] idx;
        logic [7:0]  be;
        logic [63:0] wdata;
        int          hold;
    } mem_exp_t;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        err;
        int          kind;
    } resp_exp_t;

    mem_exp_t    exp_mem_q[$];
    resp_exp_t   exp_resp_q[$];
    mem_exp_t    cur;
    resp_exp_t   got;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          cycle_cnt  = 0;
    int          accept_cyc = 0;
    int          ack_cyc    = 0;
    int          ack_delay  = 0;
    int          hold_cnt   = 0;
    int          req_cyc    = 0;
    logic        in_mem     = 1'b0;
    logic        have_cur   = 1'b0;
    logic        ready_due  = 1'b0;
    logic [63:0] rd_word    = 64'd0;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_err(resp_err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [63:0] idx, input logic [7:0] be,
                            input logic [63:0] wdata, input int hold);
        mem_exp_t e;
        e.we = we; e.idx = idx; e.be = be; e.wdata = wdata; e.hold = hold;
        exp_mem_q.push_back(e);
    endtask

    task automatic push_resp(input logic [63:0] rdata, input logic mis, input logic err, input int kind);
        resp_exp_t e;
        e.rdata = rdata; e.mis = mis; e.err = err; e.kind = kind;
        exp_resp_q.push_back(e);
    endtask

    // Called at posedge+1; presents one request for one accepted cycle, then scrambles inputs.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check_val("ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        accept_cyc   = cycle_cnt;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_addr     = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdata    = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_resp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("resp_wait", 64'(exp_resp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor and memory responder, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_mem    = 1'b0;
            have_cur  = 1'b0;
            ready_due = 1'b0;
            mem_ack   = 1'b0;
            req_cyc   = 0;
        end else begin
            if (mem_req) begin
                if (!in_mem) begin
                    in_mem   = 1'b1;
                    hold_cnt = 0;
                    req_cyc  = 0;
                    if (exp_mem_q.size() == 0) begin
                        check_val("unexpected_mem_req", 64'd1, 64'd0);
                    end else begin
                        cur      = exp_mem_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                hold_cnt++;
                if (have_cur) begin
                    check_val("mem_we", {63'd0, mem_we}, {63'd0, cur.we});
                    check_val("mem_addr", 64'(mem_addr), cur.idx);
                    check_val("mem_be", {56'd0, mem_be}, {56'd0, cur.be});
                    check_val("mem_wdata", mem_wdata, cur.wdata);
                end
                if (have_cur && req_cyc == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_word;
                    ack_cyc   = cycle_cnt;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                req_cyc++;
            end else begin
                if (in_mem && have_cur) check_val("mem_req_hold", 64'(hold_cnt), 64'(cur.hold));
                in_mem   = 1'b0;
                have_cur = 1'b0;
                mem_ack  = 1'b0;
            end

            if (ready_due) begin
                check_val("ready_after_resp", {63'd0, req_ready}, 64'd1);
                ready_due = 1'b0;
            end

            if (resp_valid) begin
                ready_due = 1'b1;
                check_val("resp_stall", {62'd0, stall, req_ready}, 64'd2);
                if (exp_resp_q.size() == 0) begin
                    check_val("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    got = exp_resp_q.pop_front();
                    check_val("resp_rdata", resp_rdata, got.rdata);
                    check_val("resp_misaligned", {63'd0, resp_misaligned}, {63'd0, got.mis});
                    check_val("resp_err", {63'd0, resp_err}, {63'd0, got.err});
                    if (got.kind == K_ACCEPT) check_val("lat_accept", 64'(cycle_cnt - accept_cyc), 64'd1);
                    if (got.kind == K_ACK)    check_val("lat_ack", 64'(cycle_cnt - ack_cyc), 64'd1);
                end
            end else begin
                check_val("resp_idle_zero", resp_rdata | {62'd0, resp_misaligned, resp_err}, 64'd0);
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    // Directed sequence.
    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_val("rst_outputs", {57'd0, stall, mem_req, resp_valid, resp_err, resp_misaligned, mem_we, 1'b0}, 64'd0);
        check_val("rst_mem_be", {56'd0, mem_be}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned double store, ack two cycles after mem_req rises.
        ack_delay = 2;
        push_mem(1'b1, 64'd3, 8'hFF, 64'h1122_3344_5566_7788, 3);
        push_resp(64'd0, 1'b0, 1'b0, K_ACK);
        issue(1'b1, 2'b11, 1'b0, 64'h18, 64'h1122_3344_5566_7788);
        check_val("busy_flags", {61'd0, stall, req_ready, mem_req}, 64'd5);
        wait_done();

        // Signed and unsigned byte loads at offset 5, same-cycle ack.
        ack_delay = 0;
        rd_word   = 64'h0000_8000_0000_0000;
        push_mem(1'b0, 64'd3, 8'hFF, 64'd0, 1);
        push_resp(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, K_ACK);
        issue(1'b0, 2'b00, 1'b0, 64'h1D, 64'h5555_5555_5555_5555);
        wait_done();
        push_mem(1'b0, 64'd3, 8'hFF, 64'd0, 1);
        push_resp(64'h0000_0000_0000_0080, 1'b0, 1'b0, K_ACK);
        issue(1'b0, 2'b00, 1'b1, 64'h1D, 64'd0);
        wait_done();

        // Half store into lanes 2..3.
        ack_delay = 1;
        push_mem(1'b1, 64'd1, 8'h0C, 64'h0000_0000_BEEF_0000, 2);
        push_resp(64'd0, 1'b0, 1'b0, K_ACK);
        issue(1'b1, 2'b01, 1'b0, 64'h0A, 64'h0000_0000_0000_BEEF);
        wait_done();

        // Signed word load from the upper half.
        rd_word = 64'h89AB_CDEF_0000_0000;
        push_mem(1'b0, 64'd2, 8'hFF, 64'd0, 2);
        push_resp(64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1'b0, K_ACK);
        issue(1'b0, 2'b10, 1'b0, 64'h14, 64'd0);
        wait_done();

        // Rejected requests: no memory traffic, response one cycle after accept.
        push_resp(64'd0, 1'b1, 1'b0, K_ACCEPT);
        issue(1'b0, 2'b10, 1'b0, 64'h06, 64'd0);
        wait_done();
        push_resp(64'd0, 1'b0, 1'b1, K_ACCEPT);
        issue(1'b0, 2'b00, 1'b0, 64'h800, 64'd0);
        wait_done();
        push_resp(64'd0, 1'b1, 1'b1, K_ACCEPT);
        issue(1'b0, 2'b01, 1'b0, 64'h801, 64'd0);
        wait_done();
        push_resp(64'd0, 1'b1, 1'b0, K_ACCEPT);
        issue(1'b1, 2'b11, 1'b0, 64'h1C, 64'hAAAA_AAAA_AAAA_AAAA);
        wait_done();

        // Timeout: no ack ever, mem_req held for TIMEOUT cycles.
        ack_delay = NEVER;
        push_mem(1'b0, 64'd4, 8'hFF, 64'd0, TIMEOUT);
        push_resp(64'd0, 1'b0, 1'b1, K_NONE);
        issue(1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
        wait_done();

        // Ack on the timeout cycle wins.
        ack_delay = TIMEOUT - 1;
        rd_word   = 64'hCAFE_F00D_1234_5678;
        push_mem(1'b0, 64'd5, 8'hFF, 64'd0, TIMEOUT);
        push_resp(64'hCAFE_F00D_1234_5678, 1'b0, 1'b0, K_ACK);
        issue(1'b0, 2'b11, 1'b1, 64'h28, 64'd0);
        wait_done();

        // Reset while a request is outstanding: dropped without a response.
        ack_delay = NEVER;
        push_mem(1'b0, 64'd6, 8'hFF, 64'd0, 0);
        push_resp(64'd0, 1'b0, 1'b0, K_NONE);
        issue(1'b0, 2'b11, 1'b0, 64'h30, 64'd0);
        check_val("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_mem_req", {63'd0, mem_req}, 64'd0);
        check_val("async_rst_stall", {63'd0, stall}, 64'd0);
        exp_resp_q.delete();
        exp_mem_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("post_rst_ready", {63'd0, req_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Normal load after the reset.
        ack_delay = 0;
        rd_word   = 64'h89AB_CDEF_0000_0000;
        push_mem(1'b0, 64'd2, 8'hFF, 64'd0, 1);
        push_resp(64'h0000_0000_89AB_CDEF, 1'b0, 1'b0, K_ACK);
        issue(1'b0, 2'b10, 1'b1, 64'h14, 64'd0);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        check_val("queues_empty", 64'(exp_resp_q.size() + exp_mem_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
